// File: rtl/time_ascii_tx.sv
// time_ascii_tx: snapshots the displayed time and sends "HH:MM:SS.CC" to the UART TX.
// Define TIME_TX_CRLF_EN to append CR LF to every frame.
module time_ascii_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [7:0] SEP_HMS  = 8'h3A;
  localparam logic [7:0] SEP_FRAC = 8'h2E;
`ifdef TIME_TX_CRLF_EN
  localparam logic [3:0] LAST = 4'd12;
`else
  localparam logic [3:0] LAST = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t     state, state_nx;
  logic [3:0] idx, idx_nx;
  logic [4:0] snap_h;
  logic [5:0] snap_m;
  logic [5:0] snap_s;
  logic [6:0] snap_c;
  logic       load;
  logic       start_nx;
  logic       done_nx;
  logic [7:0] byte_sel;

  // Tens saturate at 9 so out-of-range values still map to '0'..'9'.
  function automatic logic [7:0] tens_ch(input logic [6:0] v);
    logic [6:0] q;
    q = v / 7'd10;
    if (q > 7'd9) q = 7'd9;
    return 8'h30 + {1'b0, q};
  endfunction

  function automatic logic [7:0] ones_ch(input logic [6:0] v);
    return 8'h30 + {1'b0, v % 7'd10};
  endfunction

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      4'd0:    byte_sel = tens_ch({2'b00, snap_h});
      4'd1:    byte_sel = ones_ch({2'b00, snap_h});
      4'd2:    byte_sel = SEP_HMS;
      4'd3:    byte_sel = tens_ch({1'b0, snap_m});
      4'd4:    byte_sel = ones_ch({1'b0, snap_m});
      4'd5:    byte_sel = SEP_HMS;
      4'd6:    byte_sel = tens_ch({1'b0, snap_s});
      4'd7:    byte_sel = ones_ch({1'b0, snap_s});
      4'd8:    byte_sel = SEP_FRAC;
      4'd9:    byte_sel = tens_ch(snap_c);
      4'd10:   byte_sel = ones_ch(snap_c);
`ifdef TIME_TX_CRLF_EN
      4'd11:   byte_sel = 8'h0D;
      4'd12:   byte_sel = 8'h0A;
`endif
      default: byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 4'd0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      o_done   <= 1'b0;
      snap_h   <= '0;
      snap_m   <= '0;
      snap_s   <= '0;
      snap_c   <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      tx_start <= start_nx;
      o_done   <= done_nx;
      if (start_nx) tx_data <= byte_sel;
      if (load) begin
        snap_h <= hour;
        snap_m <= min;
        snap_s <= sec;
        snap_c <= msec;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_start) state_nx = SEND;
      SEND: if (!tx_busy) state_nx = WAIT;
      WAIT: begin
        if (tx_done) state_nx = (idx == LAST) ? IDLE : SEND;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    start_nx = 1'b0;
    done_nx  = 1'b0;
    idx_nx   = idx;
    o_busy   = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (i_start) begin
          load   = 1'b1;
          idx_nx = 4'd0;
        end
      end
      SEND: start_nx = !tx_busy;
      WAIT: begin
        if (tx_done) begin
          if (idx == LAST) begin
            done_nx = 1'b1;
            idx_nx  = 4'd0;
          end else begin
            idx_nx = idx + 4'd1;
          end
        end
      end
      default: idx_nx = 4'd0;
    endcase
  end

endmodule
